// File: rtl/core_mdu_seq_pkg.sv
// Shared types, sizes and arithmetic helpers for the RV32M multiply/divide sequencer.
package core_mdu_seq_pkg;

    localparam int MDU_XLEN  = 32;
    localparam int MDU_CNT_W = 5;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // Two's complement negate of a full 64-bit product/accumulator.
    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // Two's complement negate of a 32-bit word.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of a signed 32-bit operand (0x80000000 maps to itself, read as unsigned).
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/core_mdu_seq_if.sv
// Request/response bus between the execute stage and the multiply/divide sequencer.
interface core_mdu_seq_if;
    import core_mdu_seq_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [MDU_XLEN-1:0] src1;
    logic [MDU_XLEN-1:0] src2;
    logic                kill;
    logic                resp_valid;
    logic                resp_ready;
    logic [MDU_XLEN-1:0] resp_result;
    logic                busy;

    // Execute-stage side: issues operations, consumes results, flushes.
    modport master (
        output req_valid, req_op, src1, src2, kill, resp_ready,
        input  req_ready, resp_valid, resp_result, busy
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, src1, src2, kill, resp_ready,
        output req_ready, resp_valid, resp_result, busy
    );
endinterface

// File: rtl/core_mdu_seq_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module core_mdu_seq_step (
    input  logic        mode_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out,
    output logic        q_bit
);

    logic [32:0] add_s;
    logic [32:0] trial_s;
    logic [63:0] shl_s;

    // Compute both candidate updates and select by mode; quotient bit leaves bit 0 clear.
    always_comb begin
        add_s   = {1'b0, acc_in[63:32]} + {1'b0, operand};
        shl_s   = {acc_in[62:0], 1'b0};
        // acc_in[63] is the 33rd bit of the shifted partial remainder.
        trial_s = acc_in[63:31] - {1'b0, operand};
        acc_out = acc_in;
        q_bit   = 1'b0;
        if (mode_div) begin
            if (!trial_s[32]) begin
                acc_out = {trial_s[31:0], shl_s[31:0]};
                q_bit   = 1'b1;
            end else begin
                acc_out = shl_s;
            end
        end else begin
            if (acc_in[0]) begin
                acc_out = {add_s, acc_in[31:1]};
            end else begin
                acc_out = {1'b0, acc_in[63:1]};
            end
        end
    end

endmodule

// File: rtl/core_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-cycle loop, 1-cycle special cases.
module core_mdu_seq
    import core_mdu_seq_pkg::*;
#(
    parameter int XLEN  = MDU_XLEN,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    core_mdu_seq_if.slave mdu
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    mdu_state_e          state_r;
    mdu_state_e          state_nxt_s;
    mdu_op_e             op_r;
    logic                sign_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     operand_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [XLEN-1:0]     result_r;

    logic                accept_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s;
    logic [2*XLEN-1:0]   acc_init_s;
    logic [XLEN-1:0]     operand_init_s;
    logic                sign_init_s;
    logic [2*XLEN-1:0]   step_acc_s;
    logic                step_q_s;
    logic [2*XLEN-1:0]   acc_nxt_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     final_s;

    assign accept_s = mdu.req_valid && (state_r == MDU_IDLE) && !mdu.kill;

    core_mdu_seq_step u_step (
        .mode_div (op_r[2]),
        .acc_in   (acc_r),
        .operand  (operand_r),
        .acc_out  (step_acc_s),
        .q_bit    (step_q_s)
    );

    assign acc_nxt_s = {step_acc_s[2*XLEN-1:1], step_acc_s[0] | step_q_s};

    // Decode the incoming request: operand magnitudes, result sign, special-case shortcut.
    always_comb begin
        special_s      = 1'b0;
        special_res_s  = '0;
        acc_init_s     = {32'd0, mdu.src2};
        operand_init_s = mdu.src1;
        sign_init_s    = 1'b0;
        case (mdu.req_op)
            MDU_MUL, MDU_MULHU: begin
                acc_init_s     = {32'd0, mdu.src2};
                operand_init_s = mdu.src1;
            end
            MDU_MULH: begin
                acc_init_s     = {32'd0, abs32(mdu.src2)};
                operand_init_s = abs32(mdu.src1);
                sign_init_s    = mdu.src1[31] ^ mdu.src2[31];
            end
            MDU_MULHSU: begin
                acc_init_s     = {32'd0, mdu.src2};
                operand_init_s = abs32(mdu.src1);
                sign_init_s    = mdu.src1[31];
            end
            MDU_DIV, MDU_REM: begin
                acc_init_s     = {32'd0, abs32(mdu.src1)};
                operand_init_s = abs32(mdu.src2);
                sign_init_s    = (mdu.req_op == MDU_DIV) ? (mdu.src1[31] ^ mdu.src2[31])
                                                         : mdu.src1[31];
                if (mdu.src2 == 32'd0) begin
                    special_s     = 1'b1;
                    special_res_s = (mdu.req_op == MDU_DIV) ? 32'hFFFF_FFFF : mdu.src1;
                end else if ((mdu.src1 == 32'h8000_0000) && (mdu.src2 == 32'hFFFF_FFFF)) begin
                    special_s     = 1'b1;
                    special_res_s = (mdu.req_op == MDU_DIV) ? 32'h8000_0000 : 32'd0;
                end else begin
                    special_s     = 1'b0;
                end
            end
            MDU_DIVU, MDU_REMU: begin
                acc_init_s     = {32'd0, mdu.src1};
                operand_init_s = mdu.src2;
                if (mdu.src2 == 32'd0) begin
                    special_s     = 1'b1;
                    special_res_s = (mdu.req_op == MDU_DIVU) ? 32'hFFFF_FFFF : mdu.src1;
                end else begin
                    special_s     = 1'b0;
                end
            end
            default: begin
                special_s = 1'b0;
            end
        endcase
    end

    // Sign correction and word select applied to the final iteration's accumulator.
    always_comb begin
        prod_s  = sign_r ? neg64(acc_nxt_s) : acc_nxt_s;
        final_s = '0;
        case (op_r)
            MDU_MUL:                       final_s = acc_nxt_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU,
            MDU_MULHU:                     final_s = prod_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:             final_s = sign_r ? neg32(acc_nxt_s[XLEN-1:0])
                                                            : acc_nxt_s[XLEN-1:0];
            MDU_REM, MDU_REMU:             final_s = sign_r ? neg32(acc_nxt_s[2*XLEN-1:XLEN])
                                                            : acc_nxt_s[2*XLEN-1:XLEN];
            default:                       final_s = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= MDU_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; kill overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (mdu.kill) begin
            state_nxt_s = MDU_IDLE;
        end else begin
            case (state_r)
                MDU_IDLE: state_nxt_s = mdu.req_valid ? (special_s ? MDU_DONE : MDU_CALC) : MDU_IDLE;
                MDU_CALC: state_nxt_s = (cnt_r == LAST_CNT) ? MDU_DONE : MDU_CALC;
                MDU_DONE: state_nxt_s = mdu.resp_ready ? MDU_IDLE : MDU_DONE;
                default:  state_nxt_s = MDU_IDLE;
            endcase
        end
    end

    // Handshake and stall outputs decoded from the state register.
    always_comb begin
        mdu.req_ready   = (state_r == MDU_IDLE);
        mdu.resp_valid  = (state_r == MDU_DONE);
        mdu.busy        = (state_r != MDU_IDLE);
        mdu.resp_result = result_r;
    end

    // Datapath: latch operands on accept, iterate in CALC, capture the result when finishing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r      <= MDU_MUL;
            sign_r    <= 1'b0;
            acc_r     <= '0;
            operand_r <= '0;
            cnt_r     <= '0;
            result_r  <= '0;
        end else if (accept_s) begin
            op_r      <= mdu_op_e'(mdu.req_op);
            sign_r    <= sign_init_s;
            acc_r     <= acc_init_s;
            operand_r <= operand_init_s;
            cnt_r     <= '0;
            if (special_s) begin
                result_r <= special_res_s;
            end
        end else if ((state_r == MDU_CALC) && !mdu.kill) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
                result_r <= final_s;
            end
        end
    end

endmodule

// File: tb/tb_core_mdu_seq.sv
// Directed self-checking bench for core_mdu_seq with hand-computed RV32M results.
module tb_core_mdu_seq;
    import core_mdu_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    core_mdu_seq_if mdu_bus ();

    core_mdu_seq u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mdu_bus.slave)
    );

    // Free-running core clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_res);
        check_eq({tag, "_req_ready"},  {31'd0, mdu_bus.req_ready},  32'd1);
        check_eq({tag, "_busy"},       {31'd0, mdu_bus.busy},       32'd0);
        check_eq({tag, "_resp_valid"}, {31'd0, mdu_bus.resp_valid}, 32'd0);
        check_eq({tag, "_result"},     mdu_bus.resp_result,         exp_res);
    endtask

    // Issue one op, scramble operands after accept, measure latency, optionally hold in DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        mdu_bus.req_valid = 1'b1;
        mdu_bus.req_op    = op;
        mdu_bus.src1      = a;
        mdu_bus.src2      = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        mdu_bus.req_op    = 3'd7;
        mdu_bus.src1      = 32'hA5A5_5A5A;
        mdu_bus.src2      = 32'h0000_0000;
        while (!mdu_bus.resp_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, mdu_bus.resp_result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, {31'd0, mdu_bus.resp_valid}, 32'd1);
            check_eq({tag, "_hold_res"},   mdu_bus.resp_result,         exp);
            check_eq({tag, "_hold_ready"}, {31'd0, mdu_bus.req_ready},  32'd0);
        end
        mdu_bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.resp_ready = 1'b0;
        check_eq({tag, "_back_idle"}, {31'd0, mdu_bus.req_ready}, 32'd1);
    endtask

    // Directed sequence.
    initial begin
        errors             = 0;
        checks             = 0;
        rst_n              = 1'b0;
        mdu_bus.req_valid  = 1'b0;
        mdu_bus.req_op     = 3'd0;
        mdu_bus.src1       = 32'd0;
        mdu_bus.src2       = 32'd0;
        mdu_bus.kill       = 1'b0;
        mdu_bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset", 32'd0);
        rst_n = 1'b1;

        // Normal 32-iteration operations.
        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        run_op("mulh",   3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
        run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14,        33, 0);
        run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33, 0);

        // Single-cycle special cases.
        run_op("div0",   3'd4, 32'd55,         32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("remu0",  3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, 1, 0);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);

        // kill in IDLE blocks acceptance.
        mdu_bus.req_valid = 1'b1;
        mdu_bus.req_op    = 3'd5;
        mdu_bus.src1      = 32'd9;
        mdu_bus.src2      = 32'd3;
        mdu_bus.kill      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        mdu_bus.kill      = 1'b0;
        check_eq("kill_idle_ready", {31'd0, mdu_bus.req_ready}, 32'd1);
        check_eq("kill_idle_busy",  {31'd0, mdu_bus.busy},      32'd0);

        // kill at counter 10 of a divide, then an immediate multiply.
        mdu_bus.req_valid = 1'b1;
        mdu_bus.req_op    = 3'd5;
        mdu_bus.src1      = 32'd100;
        mdu_bus.src2      = 32'd7;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("kill_calc_busy_before", {31'd0, mdu_bus.busy}, 32'd1);
        mdu_bus.kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.kill = 1'b0;
        check_eq("kill_calc_ready",      {31'd0, mdu_bus.req_ready},  32'd1);
        check_eq("kill_calc_resp_valid", {31'd0, mdu_bus.resp_valid}, 32'd0);
        check_eq("kill_calc_busy",       {31'd0, mdu_bus.busy},       32'd0);
        run_op("mul_after_kill", 3'd0, 32'd3, 32'd5, 32'd15, 33, 0);

        // Consumer stalls for 5 cycles in DONE.
        run_op("hold", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 33, 5);

        // Reset mid-CALC.
        mdu_bus.req_valid = 1'b1;
        mdu_bus.req_op    = 3'd4;
        mdu_bus.src1      = 32'hFFFF_FFF9;
        mdu_bus.src2      = 32'd2;
        @(posedge clk);
        @(negedge clk);
        mdu_bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_mid", 32'd0);
        rst_n = 1'b1;
        run_op("divu_after_rst", 3'd5, 32'd1000, 32'd10, 32'd100, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
